fpmul_scheduler: RTL and testbench

Sequencer/arbiter that shares one single-precision (IEEE 754) multiplier unit between N_REQ requesters. Each requester presents an operand pair with a valid/ready handshake. The scheduler grants requesters round-robin, registers the operands onto the multiplier inputs and waits a fixed MUL_LAT cycles. It then captures the product and returns it on a single response channel tagged with the requester index. It sits between the datapath clients and the multiplier unit, which connects through the mul_* ports.

---
 rtl/fpmul_pkg.sv | 18 +
 rtl/rr_arbiter.sv | 35 +++
 rtl/fpmul_scheduler.sv | 128 ++++++++++++
 tb/tb_fpmul_scheduler.sv | 338 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fpmul_pkg.sv
// Shared types and constants for the fp32 multiplier scheduler.
// Holds the scheduler state encoding, operand width and index-width helper.
package fpmul_pkg;

    localparam int FP_W = 32;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_e;

    // Index width that stays at least one bit wide for single-entry vectors.
    function automatic int id_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin picker: first set request at or after ptr_i, searching cyclically.
// Purely combinational; no backpressure of its own.
module rr_arbiter
    import fpmul_pkg::*;
#(
    parameter  int N  = 2,
    localparam int IW = id_w(N)
) (
    input  logic [N-1:0]  req_i,
    input  logic [IW-1:0] ptr_i,
    output logic [N-1:0]  grant_o,
    output logic [IW-1:0] idx_o,
    output logic          any_o
);

    logic [IW-1:0] cand;
    logic          found;

    always_comb begin
        grant_o = '0;
        idx_o   = '0;
        found   = 1'b0;
        cand    = '0;
        for (int i = 0; i < N; i++) begin
            cand = IW'((int'(ptr_i) + i) % N);
            if (!found && req_i[cand]) begin
                found          = 1'b1;
                idx_o          = cand;
                grant_o[cand]  = 1'b1;
            end
        end
        any_o = found;
    end

endmodule

// File: rtl/fpmul_scheduler.sv
// Shares one fp32 multiplier between N_REQ requesters; one op in flight at a time.
// Accept-to-response MUL_LAT+1 cycles; response held until rsp_ready, no new grant meanwhile.
module fpmul_scheduler
    import fpmul_pkg::*;
#(
    parameter  int N_REQ   = 2,
    parameter  int MUL_LAT = 1,
    parameter  int CNT_W   = 16,
    localparam int ID_W    = id_w(N_REQ)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [N_REQ-1:0]        req_valid,
    input  logic [N_REQ*FP_W-1:0]   req_a,
    input  logic [N_REQ*FP_W-1:0]   req_b,
    output logic [N_REQ-1:0]        req_ready,
    output logic [FP_W-1:0]         mul_a,
    output logic [FP_W-1:0]         mul_b,
    input  logic [FP_W-1:0]         mul_r,
    output logic                    rsp_valid,
    output logic [FP_W-1:0]         rsp_data,
    output logic [ID_W-1:0]         rsp_id,
    input  logic                    rsp_ready,
    output logic                    busy,
    output logic [CNT_W-1:0]        ops_done
);

    localparam int LAT_W = id_w(MUL_LAT);

    state_e             state_q, state_d;
    logic [ID_W-1:0]    ptr_q, ptr_d;
    logic [LAT_W-1:0]   lat_q, lat_d;
    logic [FP_W-1:0]    mul_a_q, mul_a_d;
    logic [FP_W-1:0]    mul_b_q, mul_b_d;
    logic               rsp_vld_q, rsp_vld_d;
    logic [FP_W-1:0]    rsp_dat_q, rsp_dat_d;
    logic [ID_W-1:0]    rsp_id_q, rsp_id_d;
    logic [CNT_W-1:0]   ops_q, ops_d;

    logic [N_REQ-1:0]   gnt;
    logic [ID_W-1:0]    gnt_idx;
    logic               gnt_any;

    rr_arbiter #(.N(N_REQ)) u_arb (
        .req_i   (req_valid),
        .ptr_i   (ptr_q),
        .grant_o (gnt),
        .idx_o   (gnt_idx),
        .any_o   (gnt_any)
    );

    // Grants are only offered in IDLE and are suppressed while reset is held.
    assign req_ready = (state_q == IDLE && rst) ? gnt : '0;

    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        lat_d     = lat_q;
        mul_a_d   = mul_a_q;
        mul_b_d   = mul_b_q;
        rsp_vld_d = rsp_vld_q;
        rsp_dat_d = rsp_dat_q;
        rsp_id_d  = rsp_id_q;
        ops_d     = ops_q;
        case (state_q)
            IDLE: begin
                if (gnt_any) begin
                    mul_a_d  = req_a[int'(gnt_idx)*FP_W +: FP_W];
                    mul_b_d  = req_b[int'(gnt_idx)*FP_W +: FP_W];
                    rsp_id_d = gnt_idx;
                    lat_d    = LAT_W'(MUL_LAT - 1);
                    ptr_d    = ID_W'((int'(gnt_idx) + 1) % N_REQ);
                    state_d  = EXEC;
                end
            end
            EXEC: begin
                if (lat_q == '0) begin
                    rsp_dat_d = mul_r;
                    rsp_vld_d = 1'b1;
                    state_d   = RESP;
                end else begin
                    lat_d = lat_q - LAT_W'(1);
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    rsp_vld_d = 1'b0;
                    ops_d     = ops_q + CNT_W'(1);
                    state_d   = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= IDLE;
            ptr_q     <= '0;
            lat_q     <= '0;
            mul_a_q   <= '0;
            mul_b_q   <= '0;
            rsp_vld_q <= 1'b0;
            rsp_dat_q <= '0;
            rsp_id_q  <= '0;
            ops_q     <= '0;
        end else begin
            state_q   <= state_d;
            ptr_q     <= ptr_d;
            lat_q     <= lat_d;
            mul_a_q   <= mul_a_d;
            mul_b_q   <= mul_b_d;
            rsp_vld_q <= rsp_vld_d;
            rsp_dat_q <= rsp_dat_d;
            rsp_id_q  <= rsp_id_d;
            ops_q     <= ops_d;
        end
    end

    assign mul_a     = mul_a_q;
    assign mul_b     = mul_b_q;
    assign rsp_valid = rsp_vld_q;
    assign rsp_data  = rsp_dat_q;
    assign rsp_id    = rsp_id_q;
    assign busy      = (state_q != IDLE);
    assign ops_done  = ops_q;

endmodule

// File: tb/tb_fpmul_scheduler.sv
// Bench for fpmul_scheduler: MUL_LAT=1/CNT_W=2 instance with scoreboard, plus MUL_LAT=3 instance.
module tb_fpmul_scheduler;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst;
    int   n_chk  = 0;
    int   n_fail = 0;
    int   cyc    = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Instance 1: MUL_LAT=1, 2-bit counter
    logic [1:0]  d1_req_valid, d1_req_ready;
    logic [63:0] d1_req_a, d1_req_b;
    logic [31:0] d1_mul_a, d1_mul_b, d1_mul_r, d1_rsp_data;
    logic        d1_rsp_valid, d1_rsp_ready, d1_busy;
    logic [0:0]  d1_rsp_id;
    logic [1:0]  d1_ops_done;

    fpmul_scheduler #(.N_REQ(2), .MUL_LAT(1), .CNT_W(2)) u_d1 (
        .clk(clk), .rst(rst),
        .req_valid(d1_req_valid), .req_a(d1_req_a), .req_b(d1_req_b), .req_ready(d1_req_ready),
        .mul_a(d1_mul_a), .mul_b(d1_mul_b), .mul_r(d1_mul_r),
        .rsp_valid(d1_rsp_valid), .rsp_data(d1_rsp_data), .rsp_id(d1_rsp_id), .rsp_ready(d1_rsp_ready),
        .busy(d1_busy), .ops_done(d1_ops_done)
    );

    // Instance 3: MUL_LAT=3 with a two-stage pipelined multiplier model
    logic [1:0]  d3_req_valid, d3_req_ready;
    logic [63:0] d3_req_a, d3_req_b;
    logic [31:0] d3_mul_a, d3_mul_b, d3_mul_r, d3_rsp_data;
    logic        d3_rsp_valid, d3_rsp_ready, d3_busy;
    logic [0:0]  d3_rsp_id;
    logic [15:0] d3_ops_done;

    fpmul_scheduler #(.N_REQ(2), .MUL_LAT(3), .CNT_W(16)) u_d3 (
        .clk(clk), .rst(rst),
        .req_valid(d3_req_valid), .req_a(d3_req_a), .req_b(d3_req_b), .req_ready(d3_req_ready),
        .mul_a(d3_mul_a), .mul_b(d3_mul_b), .mul_r(d3_mul_r),
        .rsp_valid(d3_rsp_valid), .rsp_data(d3_rsp_data), .rsp_id(d3_rsp_id), .rsp_ready(d3_rsp_ready),
        .busy(d3_busy), .ops_done(d3_ops_done)
    );

    // Reference multiplier through double precision; exact for normals and zero used here.
    function automatic logic [63:0] f2d(input logic [31:0] f);
        if (f[30:0] == 31'd0) return {f[31], 63'd0};
        return {f[31], {3'b000, f[30:23]} + 11'd896, f[22:0], 29'd0};
    endfunction

    function automatic logic [31:0] d2f(input logic [63:0] d);
        logic [10:0] e;
        if (d[62:0] == 63'd0) return {d[63], 31'd0};
        e = d[62:52] - 11'd896;
        return {d[63], e[7:0], d[51:29]};
    endfunction

    function automatic logic [31:0] fmul(input logic [31:0] a, input logic [31:0] b);
        return d2f($realtobits($bitstoreal(f2d(a)) * $bitstoreal(f2d(b))));
    endfunction

    always_comb d1_mul_r = fmul(d1_mul_a, d1_mul_b);

    logic [31:0] p1, p2;
    always @(posedge clk) begin
        p1 <= fmul(d3_mul_a, d3_mul_b);
        p2 <= p1;
    end
    assign d3_mul_r = p2;

    typedef struct {
        logic [0:0]  id;
        logic [31:0] data;
    } exp_t;
    exp_t       sb[$];
    logic [1:0] exp_ops;
    int         exp_ptr;

    typedef struct {
        int          id;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] p;
    } vec_t;
    vec_t vecs[5];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Response scoreboard and per-cycle protocol checks for instance 1.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            #2;
            if (!rst) begin
                sb.delete();
                exp_ops = '0;
            end else begin
                chk("ops_done", {62'd0, d1_ops_done}, {62'd0, exp_ops});
                chk("req_ready onehot0", {63'd0, $onehot0(d1_req_ready)}, 64'd1);
                if (d1_busy) chk("req_ready while busy", {62'd0, d1_req_ready}, 64'd0);
                if (d1_rsp_valid && d1_rsp_ready) begin
                    if (sb.size() == 0) begin
                        chk("unexpected response", 64'd1, 64'd0);
                    end else begin
                        e = sb.pop_front();
                        chk("rsp_id", {63'd0, d1_rsp_id}, {63'd0, e.id});
                        chk("rsp_data", {32'd0, d1_rsp_data}, {32'd0, e.data});
                    end
                    exp_ops = exp_ops + 2'd1;
                end
            end
        end
    end

    task automatic issue(input int id, input logic [31:0] a, input logic [31:0] b, input logic [31:0] p);
        int n;
        @(negedge clk);
        d1_req_a[id*32 +: 32] = a;
        d1_req_b[id*32 +: 32] = b;
        d1_req_valid[id]      = 1'b1;
        sb.push_back('{1'(id), p});
        n = 0;
        #1;
        while (!d1_req_ready[id] && n < 20) begin
            @(negedge clk);
            #1;
            n++;
        end
        if (n >= 20) chk("accept timeout", 64'd0, 64'd1);
        @(negedge clk);
        d1_req_valid[id] = 1'b0;
        chk("mul_a", {32'd0, d1_mul_a}, {32'd0, a});
        chk("mul_b", {32'd0, d1_mul_b}, {32'd0, b});
        exp_ptr = (id + 1) % 2;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        @(negedge clk);
        while (d1_busy && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (d1_busy) chk("idle timeout", 64'd1, 64'd0);
    endtask

    task automatic pulse_reset();
        @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        exp_ptr = 0;
    endtask

    initial begin
        int last;
        int n;
        logic [1:0] wrap_exp[5];

        vecs[0] = '{1, 32'h40400000, 32'h40800000, 32'h41400000};
        vecs[1] = '{0, 32'hBF800000, 32'h40A00000, 32'hC0A00000};
        vecs[2] = '{1, 32'h00000000, 32'h3F800000, 32'h00000000};
        vecs[3] = '{0, 32'h3FC00000, 32'h3FC00000, 32'h40100000};
        vecs[4] = '{1, 32'h3F000000, 32'h3F000000, 32'h3E800000};
        wrap_exp = '{2'd1, 2'd2, 2'd3, 2'd0, 2'd1};

        rst = 1'b0;
        exp_ptr = 0;
        d1_req_valid = 2'b11;
        d1_req_a = '0;
        d1_req_b = '0;
        d1_rsp_ready = 1'b1;
        d3_req_valid = 2'b00;
        d3_req_a = '0;
        d3_req_b = '0;
        d3_rsp_ready = 1'b1;

        // Reset state, with requests pending during reset
        repeat (2) @(negedge clk);
        #1;
        chk("reset req_ready", {62'd0, d1_req_ready}, 64'd0);
        chk("reset busy", {63'd0, d1_busy}, 64'd0);
        chk("reset rsp_valid", {63'd0, d1_rsp_valid}, 64'd0);
        chk("reset mul_a", {32'd0, d1_mul_a}, 64'd0);
        chk("reset rsp_data", {32'd0, d1_rsp_data}, 64'd0);
        chk("reset ops_done", {62'd0, d1_ops_done}, 64'd0);
        d1_req_valid = 2'b00;
        @(negedge clk);
        rst = 1'b1;

        // Single op, MUL_LAT=1
        issue(0, 32'h3F800000, 32'h40000000, 32'h40000000);
        chk("single busy in EXEC", {63'd0, d1_busy}, 64'd1);
        chk("single rsp_valid early", {63'd0, d1_rsp_valid}, 64'd0);
        @(negedge clk);
        chk("single rsp_valid", {63'd0, d1_rsp_valid}, 64'd1);
        chk("single rsp_data", {32'd0, d1_rsp_data}, 64'h40000000);
        chk("single rsp_id", {63'd0, d1_rsp_id}, 64'd0);
        @(negedge clk);
        chk("single busy after", {63'd0, d1_busy}, 64'd0);
        chk("single ops_done", {62'd0, d1_ops_done}, 64'd1);

        // Table of single ops
        for (int i = 0; i < 5; i++) begin
            issue(vecs[i].id, vecs[i].a, vecs[i].b, vecs[i].p);
            wait_idle();
        end

        // Contention: both requesters held valid
        @(negedge clk);
        d1_req_a = {32'h3F800000, 32'h40000000};
        d1_req_b = {32'hBF800000, 32'h40400000};
        d1_req_valid = 2'b11;
        last = 0;
        for (int k = 0; k < 4; k++) begin
            n = 0;
            #1;
            while (d1_req_ready == 2'b00 && n < 20) begin
                @(negedge clk);
                #1;
                n++;
            end
            chk("contention grant", {62'd0, d1_req_ready}, 64'd1 << exp_ptr);
            if (k > 0) chk("issue spacing", 64'(cyc - last), 64'd3);
            last = cyc;
            sb.push_back('{1'(exp_ptr), (exp_ptr == 0) ? 32'h40C00000 : 32'hBF800000});
            exp_ptr = exp_ptr ^ 1;
            @(negedge clk);
        end
        d1_req_valid = 2'b00;
        wait_idle();

        // Backpressure: response held 5 cycles, competing request waits
        d1_rsp_ready = 1'b0;
        issue(0, 32'h40000000, 32'h40000000, 32'h40800000);
        @(negedge clk);
        d1_req_a[63:32] = 32'h3F800000;
        d1_req_b[63:32] = 32'h40400000;
        d1_req_valid[1] = 1'b1;
        sb.push_back('{1'b1, 32'h40400000});
        for (int i = 0; i < 5; i++) begin
            #1;
            chk("bp rsp_valid", {63'd0, d1_rsp_valid}, 64'd1);
            chk("bp rsp_data", {32'd0, d1_rsp_data}, 64'h40800000);
            chk("bp rsp_id", {63'd0, d1_rsp_id}, 64'd0);
            chk("bp req_ready", {62'd0, d1_req_ready}, 64'd0);
            chk("bp busy", {63'd0, d1_busy}, 64'd1);
            @(negedge clk);
        end
        d1_rsp_ready = 1'b1;
        @(negedge clk);
        #1;
        chk("bp idle after release", {63'd0, d1_busy}, 64'd0);
        chk("bp next grant", {62'd0, d1_req_ready}, 64'd2);
        @(negedge clk);
        d1_req_valid[1] = 1'b0;
        exp_ptr = 0;
        wait_idle();

        // Latency: MUL_LAT=3
        @(negedge clk);
        d3_req_a[31:0] = 32'h40400000;
        d3_req_b[31:0] = 32'h40800000;
        d3_req_valid = 2'b01;
        #1;
        chk("lat3 req_ready", {62'd0, d3_req_ready}, 64'd1);
        @(negedge clk);
        d3_req_valid = 2'b00;
        for (int j = 0; j < 4; j++) begin
            chk("lat3 mul_a stable", {32'd0, d3_mul_a}, 64'h40400000);
            chk("lat3 mul_b stable", {32'd0, d3_mul_b}, 64'h40800000);
            chk("lat3 rsp_valid", {63'd0, d3_rsp_valid}, (j == 3) ? 64'd1 : 64'd0);
            if (j == 3) chk("lat3 rsp_data", {32'd0, d3_rsp_data}, 64'h41400000);
            if (j < 3) @(negedge clk);
        end
        @(negedge clk);
        chk("lat3 busy after", {63'd0, d3_busy}, 64'd0);
        chk("lat3 ops_done", {48'd0, d3_ops_done}, 64'd1);

        // Reset in the middle of EXEC aborts the op
        @(negedge clk);
        d1_req_a[31:0] = 32'h40000000;
        d1_req_b[31:0] = 32'h40400000;
        d1_req_valid = 2'b01;
        #1;
        chk("abort accept", {62'd0, d1_req_ready}, 64'd1);
        @(negedge clk);
        d1_req_valid = 2'b00;
        chk("abort in EXEC", {63'd0, d1_busy}, 64'd1);
        rst = 1'b0;
        #1;
        chk("abort busy", {63'd0, d1_busy}, 64'd0);
        chk("abort rsp_valid", {63'd0, d1_rsp_valid}, 64'd0);
        chk("abort mul_a", {32'd0, d1_mul_a}, 64'd0);
        chk("abort mul_b", {32'd0, d1_mul_b}, 64'd0);
        chk("abort rsp_data", {32'd0, d1_rsp_data}, 64'd0);
        chk("abort rsp_id", {63'd0, d1_rsp_id}, 64'd0);
        chk("abort ops_done", {62'd0, d1_ops_done}, 64'd0);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        exp_ptr = 0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("abort no response", {63'd0, d1_rsp_valid}, 64'd0);
        end
        issue(1, 32'h3F800000, 32'h40400000, 32'h40400000);
        wait_idle();
        chk("abort ops after req1", {62'd0, d1_ops_done}, 64'd1);

        // Counter wrap with CNT_W=2
        pulse_reset();
        for (int i = 0; i < 5; i++) begin
            issue(i % 2, 32'h3F800000, 32'h3F800000, 32'h3F800000);
            wait_idle();
            chk("wrap ops_done", {62'd0, d1_ops_done}, {62'd0, wrap_exp[i]});
        end

        repeat (3) @(negedge clk);
        chk("scoreboard drained", 64'(sb.size()), 64'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation still running at 500000, expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
